// File: rtl/inst_fetch_stage.sv
// RV32I fetch stage: owns the fetch PC and queues ROM words for decode over valid/ready.
// Optional misaligned-redirect trap is enabled with the FETCH_MISALIGN_TRAP_EN macro.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_misalign
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_mem_q [QUEUE_DEPTH];
    logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]   redirect_target;
    logic          halted;
    logic          pop;
    logic          push;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halted_q, halted_d;

    // A misaligned target is kept verbatim so the trap handler sees the faulting address.
    assign redirect_target = redirect_pc;
    assign halted          = halted_q;
    assign fetch_misalign  = halted_q;

    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign halted          = 1'b0;
    assign fetch_misalign  = 1'b0;
`endif

    assign rom_addr = fetch_pc_q;
    assign id_valid = (count_q != '0);
    assign pop      = id_valid & id_ready;
    assign push     = !redirect_valid && ((count_q < DEPTH_C) || pop) && !halted;

    // Head fields are forced to zero while empty so decode never sees stale storage.
    assign id_inst     = id_valid ? inst_mem_q[head_q] : 32'h0;
    assign id_pc       = id_valid ? pc_mem_q[head_q]   : 32'h0;
    assign id_pc_plus4 = id_valid ? (pc_mem_q[head_q] + 32'd4) : 32'h0;

    // NOTE: every _d gets its default first, so no path through this block can infer a latch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage has no reset; occupancy is tracked by count_q and outputs are masked.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[tail_q] <= rom_inst;
            pc_mem_q[tail_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: per-cycle vector table plus a scoreboard of PCs expected at decode.
module tb_inst_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_misalign;

    inst_fetch_stage #(
        .RESET_PC    (32'h0000_0100),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    assign rom_inst = rom_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        sb_en;   // this edge fetches sb_pc, which decode must later accept
        logic [31:0] sb_pc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] erom;
        logic        emis;
    } vec_t;

    localparam int NV        = 30;
    localparam int ASYNC_ROW = 22;

    vec_t        tbl [NV];
    logic [31:0] sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;

        //           rst  rv   rpc            rdy  sb   sb_pc          ev   epc            erom           emis
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,       1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b1, 32'h100,      32'h104,       1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b1, 32'h104,      32'h108,       1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      32'h10C,       1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,       1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b1, 32'h100,      32'h104,       1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104,      1'b1, 32'h100,      32'h108,       1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      32'h108,       1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      32'h108,       1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      32'h108,       1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      1'b1, 32'h104,      32'h10C,       1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      32'h110,       1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h10C,      32'h114,       1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h10C,      32'h114,       1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'h400,      1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h400,       1'b0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h400,      1'b1, 32'h400,      32'h404,       1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h404,      32'h408,       1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        32'hFFFF_FFFC, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0,       1'b0};
        tbl[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 32'h0,        32'h4,         1'b0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,         1'b0};
        tbl[21] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'hC,         1'b0};
        tbl[22] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,       1'b0};
        tbl[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b1, 32'h100,      32'h104,       1'b0};
        tbl[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      32'h108,       1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        tbl[25] = '{1'b0, 1'b1, 32'h202,      1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h202,       1'b1};
        tbl[26] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h202,       1'b1};
`else
        tbl[25] = '{1'b0, 1'b1, 32'h202,      1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h200,       1'b0};
        tbl[26] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      32'h204,       1'b0};
`endif
        tbl[27] = '{1'b0, 1'b1, 32'h300,      1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h300,       1'b0};
        tbl[28] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      1'b1, 32'h300,      32'h304,       1'b0};
        tbl[29] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h304,      32'h308,       1'b0};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            // Mid-cycle reset with a full queue must clear the outputs without waiting for an edge.
            if (i == ASYNC_ROW) begin
                rst = 1'b1;
                #1;
                check("async_rst_valid", {31'h0, id_valid}, 32'h0);
                check("async_rst_pc", id_pc, 32'h0);
                check("async_rst_rom_addr", rom_addr, 32'h100);
            end

            if (tbl[i].sb_en) begin
                sb.push_back(tbl[i].sb_pc);
            end

            // A handshake in this cycle hands the head to decode; it must be the oldest expected PC.
            if (!tbl[i].rst && !tbl[i].rv && tbl[i].rdy && id_valid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_pop", id_pc, 32'hDEAD_BEEF);
                end else begin
                    exp_pc = sb.pop_front();
                    check("pop_pc", id_pc, exp_pc);
                    check("pop_inst", id_inst, exp_pc ^ 32'hA5A5_0000);
                    check("pop_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
                end
            end

            rst            = tbl[i].rst;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            id_ready       = tbl[i].rdy;
            @(posedge clk);
            @(negedge clk);

            check($sformatf("row%0d_valid", i), {31'h0, id_valid}, {31'h0, tbl[i].ev});
            check($sformatf("row%0d_pc", i), id_pc, tbl[i].epc);
            check($sformatf("row%0d_rom_addr", i), rom_addr, tbl[i].erom);
            check($sformatf("row%0d_misalign", i), {31'h0, fetch_misalign}, {31'h0, tbl[i].emis});
            if (!tbl[i].ev) begin
                check($sformatf("row%0d_empty_inst", i), id_inst, 32'h0);
                check($sformatf("row%0d_empty_pc4", i), id_pc_plus4, 32'h0);
            end
        end

        check("sb_drain", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
